// File: rtl/fp_issue_pkg.sv
// Shared definitions for the FP issue buffer and the FloatingPointUnit it feeds.
// The optional same-cycle bypass of the buffer is enabled with FP_ISSUE_BYPASS_EN.
package fp_issue_pkg;

    localparam int FLOAT_OP_W = 5;
    localparam int REG_TAG_W  = 5;
    localparam int FP_XLEN    = 32;

    // floatOp encodings understood by the FloatingPointUnit
    localparam logic [FLOAT_OP_W-1:0] FOP_FADD   = 5'h00;
    localparam logic [FLOAT_OP_W-1:0] FOP_FSUB   = 5'h01;
    localparam logic [FLOAT_OP_W-1:0] FOP_FMUL   = 5'h02;
    localparam logic [FLOAT_OP_W-1:0] FOP_FDIV   = 5'h03;
    localparam logic [FLOAT_OP_W-1:0] FOP_FSQRT  = 5'h04;
    localparam logic [FLOAT_OP_W-1:0] FOP_FMADD  = 5'h05;
    localparam logic [FLOAT_OP_W-1:0] FOP_FMSUB  = 5'h06;
    localparam logic [FLOAT_OP_W-1:0] FOP_FCVT   = 5'h07;
    localparam logic [FLOAT_OP_W-1:0] FOP_FCMP   = 5'h08;

    // Payload layout at the default operand width; field order is the bus order.
    typedef struct packed {
        logic [FLOAT_OP_W-1:0] float_op;
        logic [FP_XLEN-1:0]    operand1;
        logic [FP_XLEN-1:0]    operand2;
        logic [FP_XLEN-1:0]    operand3;
        logic [REG_TAG_W-1:0]  rd;
    } fp_issue_entry_t;

    function automatic int entry_width(input int xlen);
        return FLOAT_OP_W + 3 * xlen + REG_TAG_W;
    endfunction

endpackage

// File: rtl/fp_issue_mem.sv
// Issue-buffer storage: DEPTH x W register file, synchronous write, asynchronous read.
// Contents are deliberately not reset; occupancy is tracked by the owner.
module fp_issue_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 106,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fp_issue_buffer.sv
// FIFO issue buffer between FP decode and the FloatingPointUnit.
// Define FP_ISSUE_BYPASS_EN to let an operation reach the FPU in the same cycle when empty.
module fp_issue_buffer
    import fp_issue_pkg::*;
#(
    parameter int DEPTH = 4,  // power of two, >= 2
    parameter int XLEN  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [FLOAT_OP_W-1:0]        in_floatOp_i,
    input  logic [XLEN-1:0]              in_operand1_i,
    input  logic [XLEN-1:0]              in_operand2_i,
    input  logic [XLEN-1:0]              in_operand3_i,
    input  logic [REG_TAG_W-1:0]         in_rd_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [FLOAT_OP_W-1:0]        floatOp_o,
    output logic [XLEN-1:0]              operand1_o,
    output logic [XLEN-1:0]              operand2_o,
    output logic [XLEN-1:0]              operand3_o,
    output logic [REG_TAG_W-1:0]         rd_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = entry_width(XLEN);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_entry;
    logic [EW-1:0] out_entry;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          store;
    logic          pop_mem;

    assign in_entry = {in_floatOp_i, in_operand1_i, in_operand2_i, in_operand3_i, in_rd_i};

    // Handshake: a transfer happens on a side when valid && ready && !flush_i at the
    // rising edge; in_ready_o depends only on occupancy, never on out_ready_i.
    assign in_ready_o = (count != CW'(DEPTH));

`ifdef FP_ISSUE_BYPASS_EN
    assign bypass    = rst_i && !flush_i && in_valid_i && (count == '0);
    assign out_entry = !out_valid_o ? '0 : (bypass ? in_entry : head_entry);
`else
    assign bypass    = 1'b0;
    assign out_entry = out_valid_o ? head_entry : '0;
`endif

    assign out_valid_o = (count != '0) || bypass;
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;
    // A bypassed operation taken by the FPU is never written into storage.
    assign store       = push && !(bypass && out_ready_i);
    assign pop_mem     = pop && !bypass;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_mem) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(store) - CW'(pop_mem);
        end
    end

    fp_issue_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk     (clk_i),
        .wr_en   (store),
        .wr_addr (wr_ptr),
        .wr_data (in_entry),
        .rd_addr (rd_ptr),
        .rd_data (head_entry)
    );

    assign {floatOp_o, operand1_o, operand2_o, operand3_o, rd_o} = out_entry;
    assign count_o = count;

endmodule

// File: tb/tb_fp_issue_buffer.sv
// Self-checking bench for fp_issue_buffer: hand-written vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fp_issue_buffer;
    import fp_issue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int EW    = FLOAT_OP_W + 3 * XLEN + REG_TAG_W;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef FP_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  flush_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [FLOAT_OP_W-1:0] in_floatOp_i;
    logic [XLEN-1:0]       in_operand1_i;
    logic [XLEN-1:0]       in_operand2_i;
    logic [XLEN-1:0]       in_operand3_i;
    logic [REG_TAG_W-1:0]  in_rd_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [FLOAT_OP_W-1:0] floatOp_o;
    logic [XLEN-1:0]       operand1_o;
    logic [XLEN-1:0]       operand2_o;
    logic [XLEN-1:0]       operand3_o;
    logic [REG_TAG_W-1:0]  rd_o;
    logic [CW-1:0]         count_o;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    fp_issue_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_floatOp_i  (in_floatOp_i),
        .in_operand1_i (in_operand1_i),
        .in_operand2_i (in_operand2_i),
        .in_operand3_i (in_operand3_i),
        .in_rd_i       (in_rd_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .floatOp_o     (floatOp_o),
        .operand1_o    (operand1_o),
        .operand2_o    (operand2_o),
        .operand3_o    (operand3_o),
        .rd_o          (rd_o),
        .count_o       (count_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] cur_in();
        return {in_floatOp_i, in_operand1_i, in_operand2_i, in_operand3_i, in_rd_i};
    endfunction

    function automatic logic [EW-1:0] dut_payload();
        return {floatOp_o, operand1_o, operand2_o, operand3_o, rd_o};
    endfunction

    // ---------------- reference model ----------------
    task automatic model_expect(output bit ov, output bit ir, output int n, output logic [EW-1:0] pay);
        n   = exp_q.size();
        ir  = (n != DEPTH);
        ov  = (n != 0) || (BYP && in_valid_i && !flush_i);
        pay = !ov ? '0 : ((n != 0) ? exp_q[0] : cur_in());
    endtask

    task automatic model_edge();
        bit ov, ir, take, put;
        int n;
        logic [EW-1:0] pay;
        model_expect(ov, ir, n, pay);
        if (flush_i) begin
            exp_q.delete();
        end else begin
            take = ov && out_ready_i;
            put  = in_valid_i && ir;
            if (take && n != 0) void'(exp_q.pop_front());
            if (put && !(take && n == 0)) exp_q.push_back(cur_in());
        end
    endtask

    task automatic check_outputs(input string tag);
        bit ov, ir;
        int n;
        logic [EW-1:0] pay;
        model_expect(ov, ir, n, pay);
        check({tag, ".out_valid"}, out_valid_o, ov);
        check({tag, ".in_ready"}, in_ready_o, ir);
        check({tag, ".count"}, count_o, n);
        check({tag, ".payload"}, dut_payload(), pay);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input bit r, input bit f, input fp_issue_entry_t e);
        in_valid_i    = v;
        out_ready_i   = r;
        flush_i       = f;
        in_floatOp_i  = e.float_op;
        in_operand1_i = e.operand1;
        in_operand2_i = e.operand2;
        in_operand3_i = e.operand3;
        in_rd_i       = e.rd;
    endtask

    function automatic fp_issue_entry_t mk(input logic [4:0] fop, input logic [4:0] rd);
        fp_issue_entry_t e;
        e.float_op = fop;
        e.operand1 = 32'h1000_0000 + {27'd0, rd};
        e.operand2 = 32'h2000_0000 + {27'd0, rd};
        e.operand3 = 32'h3000_0000 + {27'd0, rd};
        e.rd       = rd;
        return e;
    endfunction

    function automatic fp_issue_entry_t rnd_entry();
        fp_issue_entry_t e;
        e.float_op = 5'($urandom_range(0, 31));
        e.operand1 = $urandom;
        e.operand2 = $urandom;
        e.operand3 = $urandom;
        e.rd       = 5'($urandom_range(0, 31));
        return e;
    endfunction

    // compare just before the edge, advance the model on the edge
    task automatic step(input string tag);
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          v;
        bit          r;
        bit          f;
        logic [4:0]  rd;
        bit          e_ov;
        bit          e_ir;
        int          e_cnt;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tbl[11];
    fp_issue_entry_t e;

    initial begin
        // fill (then overfill) with FPU stalled, drain, push+pop, hold, flush with push pending
        tbl[0]  = '{1, 0, 0, 5'd1, BYP, 1, 0, (BYP ? 5'd1 : 5'd0)};
        tbl[1]  = '{1, 0, 0, 5'd2, 1, 1, 1, 5'd1};
        tbl[2]  = '{1, 0, 0, 5'd3, 1, 1, 2, 5'd1};
        tbl[3]  = '{1, 0, 0, 5'd4, 1, 1, 3, 5'd1};
        tbl[4]  = '{1, 0, 0, 5'd5, 1, 0, 4, 5'd1};
        tbl[5]  = '{0, 1, 0, 5'd0, 1, 0, 4, 5'd1};
        tbl[6]  = '{1, 1, 0, 5'd6, 1, 1, 3, 5'd2};
        tbl[7]  = '{0, 0, 0, 5'd0, 1, 1, 3, 5'd3};
        tbl[8]  = '{0, 0, 0, 5'd0, 1, 1, 3, 5'd3};
        tbl[9]  = '{1, 1, 1, 5'd7, 1, 1, 3, 5'd3};
        tbl[10] = '{0, 0, 0, 5'd0, 0, 1, 0, 5'd0};

        // reset block: outputs quiet while reset is low, even with a pending input
        rst_i = 1'b0;
        drive(1, 1, 0, mk(FOP_FMUL, 5'd9));
        #3;
        check("reset.out_valid", out_valid_o, 0);
        check("reset.in_ready", in_ready_o, 1);
        check("reset.count", count_o, 0);
        check("reset.payload", dut_payload(), 0);
        drive(0, 0, 0, mk(5'd0, 5'd0));
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        // table-driven vectors
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].f, mk(5'(i), tbl[i].rd));
            @(negedge clk);
            check($sformatf("tbl%0d.out_valid", i), out_valid_o, tbl[i].e_ov);
            check($sformatf("tbl%0d.in_ready", i), in_ready_o, tbl[i].e_ir);
            check($sformatf("tbl%0d.count", i), count_o, tbl[i].e_cnt);
            check($sformatf("tbl%0d.rd", i), rd_o, tbl[i].e_rd);
            @(posedge clk);
            model_edge();
            #1;
        end

        // single push with FPU ready; latency depends on bypass
        e.float_op = 5'h01;
        e.operand1 = 32'h3F80_0000;
        e.operand2 = 32'h4000_0000;
        e.operand3 = 32'h0;
        e.rd       = 5'd3;
        drive(1, 1, 0, e);
        step("single_push");
        drive(0, 1, 0, mk(5'd0, 5'd0));
        @(negedge clk);
        check("single.out_valid", out_valid_o, !BYP);
        check("single.payload", dut_payload(), BYP ? '0 : {5'h01, 32'h3F80_0000, 32'h4000_0000, 32'h0, 5'd3});
        @(posedge clk);
        model_edge();
        #1;
        check("single.count_after", count_o, 0);

        // fill, then stream with both sides active for 8 cycles
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, rnd_entry());
            step("fill");
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, rnd_entry());
            step("stream");
            check("stream.count_bound", count_o <= DEPTH, 1);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(0, 1, 0, mk(5'd0, 5'd0));
            step("drain");
        end
        check("drain.count", count_o, 0);

        // empty buffer, FPU ready, rd=7: same-cycle only with bypass
        drive(1, 1, 0, mk(FOP_FADD, 5'd7));
        #1;
        check("bypass.out_valid", out_valid_o, BYP);
        check("bypass.rd", rd_o, BYP ? 5'd7 : 5'd0);
        step("bypass");
        check("bypass.count_after", count_o, BYP ? 0 : 1);
        drive(0, 1, 0, mk(5'd0, 5'd0));
        step("bypass_next");
        step("bypass_idle");

        // asynchronous reset mid-cycle with two entries held
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, rnd_entry());
            step("pre_reset");
        end
        drive(0, 0, 0, mk(5'd0, 5'd0));
        #2;
        rst_i = 1'b0;
        #1;
        check("async_reset.out_valid", out_valid_o, 0);
        check("async_reset.count", count_o, 0);
        check("async_reset.in_ready", in_ready_o, 1);
        check("async_reset.payload", dut_payload(), 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        step("post_reset");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0, rnd_entry());
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_issue_buffer.md
FP_ISSUE_BUFFER -- requirements
Module: fp_issue_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffer entries; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the operand width.
REQ-003 clk_i  input  1  Single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  Reset; asynchronous and active-low.
REQ-005 flush_i  input  1  Discards all buffered entries (branch mispredict or trap).
REQ-006 in_valid_i  input  1  Decode presents an FP operation.
REQ-007 in_ready_o  output  1  The buffer can accept an entry.
REQ-008 in_floatOp_i  input  5  FP operation code.
REQ-009 in_operand1_i, in_operand2_i, in_operand3_i  input  XLEN each  Source operands.
REQ-010 in_rd_i  input  5  Destination register tag.
REQ-011 out_valid_o  output  1  The head entry is presented to the FloatingPointUnit.
REQ-012 out_ready_i  input  1  The FloatingPointUnit accepts the head entry.
REQ-013 floatOp_o (5), operand1_o, operand2_o, operand3_o (XLEN each), rd_o (5)  output  Head entry payload.
REQ-014 count_o  output  $clog2(DEPTH+1)  Number of occupied entries.

Function
REQ-015 A push SHALL occur on a cycle with in_valid_i && in_ready_o && !flush_i; a pop SHALL occur on a cycle with out_valid_o && out_ready_i && !flush_i.
REQ-016 in_ready_o SHALL be (count_o != DEPTH); it SHALL NOT depend combinationally on out_ready_i.
REQ-017 out_valid_o SHALL be (count_o != 0), except as modified by REQ-026.
REQ-018 Entries SHALL leave in FIFO order; the payload is the 5+3*XLEN+5 = 106-bit concatenation {floatOp, op1, op2, op3, rd} at default XLEN.
REQ-019 Push-to-out_valid_o latency SHALL be 1 cycle when the buffer is empty.
REQ-020 While out_valid_o=1 and out_ready_i=0, the payload outputs SHALL be held stable.
REQ-021 When out_valid_o=0, all payload outputs SHALL be driven to zero.
REQ-022 A simultaneous push and pop SHALL leave count_o unchanged, and the pushed entry SHALL be enqueued behind the remaining entries.
REQ-023 The read and write pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-024 When flush_i=1, the pointers and count SHALL be cleared at the next edge, and any push or pop on that cycle SHALL be ignored; flush_i SHALL have priority over all other events.

Reset
REQ-025 While rst_i=0, regardless of the clock: the pointers and count_o SHALL be 0, out_valid_o SHALL be 0, in_ready_o SHALL be 1, and the payload outputs SHALL be 0; the storage array SHALL NOT be reset. Reset asserted mid-transfer SHALL discard all entries.

Configuration
REQ-026 With FP_ISSUE_BYPASS_EN defined, when count_o=0 and in_valid_i=1 and flush_i=0:
- out_valid_o SHALL be 1 in the same cycle, with the payload taken directly from the in_* inputs.
- If out_ready_i=1 on that cycle, the entry SHALL NOT be stored and count_o SHALL stay 0.
REQ-027 Without FP_ISSUE_BYPASS_EN, no combinational path SHALL exist from in_* to out_*, and REQ-019 latency applies.

Structure
REQ-028 Package fp_issue_pkg SHALL hold:
- FLOAT_OP_W=5 and REG_TAG_W=5;
- the fp_issue_entry_t payload struct;
- the floatOp encoding constants shared with the FloatingPointUnit.
REQ-029 Storage SHALL be one sub-module, fp_issue_mem: DEPTH x entry register file, one synchronous write port, one asynchronous read port; pointer and count logic stays in fp_issue_buffer.

Verification
REQ-030 Reset then a single push of floatOp=5'h01, op1=32'h3F800000, op2=32'h40000000, rd=5'd3 with out_ready_i=1 -> out_valid_o=1 one cycle later carrying those values, then count_o=0.
REQ-031 Five pushes with out_ready_i=0 and DEPTH=4 -> in_ready_o=0 after the 4th push, the 5th is not accepted, count_o=4, and the head still holds the 1st entry.
REQ-032 Full buffer with in_valid_i=1 and out_ready_i=1 held for 8 cycles -> pops in order, pointers wrap, no entry is lost or duplicated, and count_o never exceeds 4.
REQ-033 flush_i=1 with count_o=3 and a push pending -> count_o=0 and out_valid_o=0 at the next cycle; the pushed entry never appears at the outputs.
REQ-034 With FP_ISSUE_BYPASS_EN, empty buffer, in_valid_i=1, out_ready_i=1, rd=5'd7 -> out_valid_o=1 with rd_o=7 in the same cycle and count_o stays 0; without the macro, out_valid_o rises one cycle later.
REQ-035 rst_i driven low asynchronously mid-cycle with count_o=2 -> out_valid_o=0 and count_o=0 immediately, before the next clock edge.
